mode_start_ctrl: RTL and testbench

- Parametrised front-panel control sequencer for the SoC top.
- Synchronises and debounces the start button and the N mode switches, validates the selection, and issues a one-cycle start pulse to the selected processing engine (e.g. image path, Sobel/VGA path).
- Tracks that engine until it reports done, and drives the mode/idle LEDs and an optional completion beep.
- Replaces the fixed two-mode switch/LED handling with N modes, illegal-selection detection and engine done tracking.

---
 rtl/mode_start_ctrl.sv | 273 +++++++++++++++++++++++++++
 tb/tb_mode_start_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mode_start_ctrl.sv
// -----------------------------------------------------------------------------
// mode_start_ctrl
//
// Front-panel control sequencer. Synchronises and debounces the start button,
// synchronises the N mode switches, validates the selection, issues a one-cycle
// start pulse to the selected engine and tracks it until that engine reports
// done. Drives mode/idle LEDs, an error indication and an optional beep.
//
// Optional feature macro: DONE_BEEP_EN
//   defined   : buzzer_o beeps for BEEP_CYCLES cycles after a completion when
//               buzzer_mode_i is high in the DONE cycle.
//   undefined : buzzer_o tied low, buzzer_mode_i unused, no beep counter.
//
// Ports:
//   clk            system clock
//   rst            asynchronous active-high reset
//   mode_sw_i      raw mode switches (level)
//   start_i        raw start button, active high
//   buzzer_mode_i  beep-enable switch
//   done_i         per-engine completion pulse (clk domain)
//   mode_start_o   one-hot one-cycle start pulse to the selected engine
//   mode_led_o     one-hot run LED; all ones during an error
//   led_idle_o     high in IDLE
//   busy_o         high in RUN
//   active_mode_o  index of the latched mode, held outside RUN
//   done_o         one-cycle pulse on accepted completion
//   err_o          illegal-selection indication, ERR_CYCLES long
//   buzzer_o       beep output
// -----------------------------------------------------------------------------
module mode_start_ctrl #(
   parameter int N_MODES         = 2,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int ERR_CYCLES      = 32,
   parameter int BEEP_CYCLES     = 64,
   localparam int MODE_W         = (N_MODES > 1) ? $clog2(N_MODES) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_MODES-1:0] mode_sw_i,
   input  logic               start_i,
   input  logic               buzzer_mode_i,
   input  logic [N_MODES-1:0] done_i,
   output logic [N_MODES-1:0] mode_start_o,
   output logic [N_MODES-1:0] mode_led_o,
   output logic               led_idle_o,
   output logic               busy_o,
   output logic [MODE_W-1:0]  active_mode_o,
   output logic               done_o,
   output logic               err_o,
   output logic               buzzer_o
);

   localparam int DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int ERR_W = (ERR_CYCLES > 1) ? $clog2(ERR_CYCLES) : 1;
   localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [ERR_W-1:0] ERR_MAX = ERR_W'(ERR_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_ERR  = 2'd3
   } state_t;

   // True when exactly one bit of v is set.
   function automatic logic is_onehot(input logic [N_MODES-1:0] v);
      return (v != {N_MODES{1'b0}}) &&
             ((v & (v - N_MODES'(1))) == {N_MODES{1'b0}});
   endfunction

   // Index of the set bit of a one-hot vector.
   function automatic logic [MODE_W-1:0] onehot_to_idx(input logic [N_MODES-1:0] v);
      logic [MODE_W-1:0] idx;
      idx = {MODE_W{1'b0}};
      for (int i = 0; i < N_MODES; i++) begin
         if (v[i]) begin
            idx = MODE_W'(i);
         end
      end
      return idx;
   endfunction

   // Synchroniser stages
   logic               start_s1_q, start_s2_q;
   logic [N_MODES-1:0] mode_s1_q, mode_s2_q;

   // Debounce state
   logic [DB_W-1:0] db_cnt_q;
   logic            db_level_q;
   logic            db_prev_q;
   logic            start_evt_q;

   // FSM state and registered outputs
   state_t             state_q;
   logic [N_MODES-1:0] mode_start_q;
   logic [N_MODES-1:0] mode_led_q;
   logic               led_idle_q;
   logic               busy_q;
   logic [MODE_W-1:0]  active_mode_q;
   logic               done_q;
   logic               err_q;
   logic [ERR_W-1:0]   err_cnt_q;

   logic               sel_legal_s;
   logic [MODE_W-1:0]  sel_idx_s;

   // Two-flop synchronisers for the button and the mode switches
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_s1_q <= 1'b0;
         start_s2_q <= 1'b0;
         mode_s1_q  <= {N_MODES{1'b0}};
         mode_s2_q  <= {N_MODES{1'b0}};
      end else begin
         start_s1_q <= start_i;
         start_s2_q <= start_s1_q;
         mode_s1_q  <= mode_sw_i;
         mode_s2_q  <= mode_s1_q;
      end
   end

   // Debounce: the level flips only after DEBOUNCE_CYCLES consecutive
   // disagreeing samples; the rising edge is registered into a start event.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt_q    <= {DB_W{1'b0}};
         db_level_q  <= 1'b0;
         db_prev_q   <= 1'b0;
         start_evt_q <= 1'b0;
      end else begin
         if (start_s2_q != db_level_q) begin
            if (db_cnt_q == DB_MAX) begin
               db_level_q <= ~db_level_q;
               db_cnt_q   <= {DB_W{1'b0}};
            end else begin
               db_cnt_q <= db_cnt_q + DB_W'(1);
            end
         end else begin
            db_cnt_q <= {DB_W{1'b0}};
         end
         db_prev_q   <= db_level_q;
         start_evt_q <= db_level_q & ~db_prev_q;
      end
   end

   // Selection validation from the synchronised switches
   always_comb begin
      sel_legal_s = is_onehot(mode_s2_q);
      sel_idx_s   = onehot_to_idx(mode_s2_q);
   end

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         mode_start_q  <= {N_MODES{1'b0}};
         mode_led_q    <= {N_MODES{1'b0}};
         led_idle_q    <= 1'b1;
         busy_q        <= 1'b0;
         active_mode_q <= {MODE_W{1'b0}};
         done_q        <= 1'b0;
         err_q         <= 1'b0;
         err_cnt_q     <= {ERR_W{1'b0}};
      end else begin
         // Pulse outputs default low each cycle
         mode_start_q <= {N_MODES{1'b0}};
         done_q       <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start_evt_q) begin
                  if (sel_legal_s) begin
                     state_q       <= ST_RUN;
                     active_mode_q <= sel_idx_s;
                     mode_start_q  <= mode_s2_q;
                     mode_led_q    <= mode_s2_q;
                     busy_q        <= 1'b1;
                     led_idle_q    <= 1'b0;
                  end else begin
                     state_q    <= ST_ERR;
                     err_q      <= 1'b1;
                     err_cnt_q  <= {ERR_W{1'b0}};
                     mode_led_q <= {N_MODES{1'b1}};
                     led_idle_q <= 1'b0;
                  end
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_RUN: begin
               // Start events are not looked at here, so a coincident
               // start is dropped when done wins.
               if (done_i[active_mode_q]) begin
                  state_q    <= ST_DONE;
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  mode_led_q <= {N_MODES{1'b0}};
               end else begin
                  state_q <= ST_RUN;
               end
            end
            ST_DONE: begin
               state_q    <= ST_IDLE;
               led_idle_q <= 1'b1;
            end
            ST_ERR: begin
               if (err_cnt_q == ERR_MAX) begin
                  state_q    <= ST_IDLE;
                  err_q      <= 1'b0;
                  err_cnt_q  <= {ERR_W{1'b0}};
                  mode_led_q <= {N_MODES{1'b0}};
                  led_idle_q <= 1'b1;
               end else begin
                  err_cnt_q <= err_cnt_q + ERR_W'(1);
               end
            end
            default: begin
               state_q      <= ST_IDLE;
               mode_start_q <= {N_MODES{1'b0}};
               mode_led_q   <= {N_MODES{1'b0}};
               led_idle_q   <= 1'b1;
               busy_q       <= 1'b0;
               err_q        <= 1'b0;
               err_cnt_q    <= {ERR_W{1'b0}};
            end
         endcase
      end
   end

`ifdef DONE_BEEP_EN
   localparam int BEEP_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;
   localparam logic [BEEP_W-1:0] BEEP_MAX = BEEP_W'(BEEP_CYCLES - 1);

   logic              buzzer_q;
   logic [BEEP_W-1:0] beep_cnt_q;

   // Beep timer: armed from the DONE cycle, runs independently of the FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buzzer_q   <= 1'b0;
         beep_cnt_q <= {BEEP_W{1'b0}};
      end else begin
         if (state_q == ST_DONE && buzzer_mode_i) begin
            buzzer_q   <= 1'b1;
            beep_cnt_q <= {BEEP_W{1'b0}};
         end else if (buzzer_q) begin
            if (beep_cnt_q == BEEP_MAX) begin
               buzzer_q   <= 1'b0;
               beep_cnt_q <= {BEEP_W{1'b0}};
            end else begin
               beep_cnt_q <= beep_cnt_q + BEEP_W'(1);
            end
         end else begin
            beep_cnt_q <= {BEEP_W{1'b0}};
         end
      end
   end

   assign buzzer_o = buzzer_q;
`else
   logic [32:0] unused_beep_s;
   assign unused_beep_s = {buzzer_mode_i, 32'(BEEP_CYCLES)};
   assign buzzer_o      = 1'b0;
`endif

   assign mode_start_o  = mode_start_q;
   assign mode_led_o    = mode_led_q;
   assign led_idle_o    = led_idle_q;
   assign busy_o        = busy_q;
   assign active_mode_o = active_mode_q;
   assign done_o        = done_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_mode_start_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mode_start_ctrl
//
// Directed bench for mode_start_ctrl with N_MODES=2, DEBOUNCE_CYCLES=4,
// ERR_CYCLES=32, BEEP_CYCLES=64. A vector table covers the normal start/done
// sequence cycle by cycle; hand-written sequences cover reset, bounce,
// illegal selections, run interference, async reset mid-run and the beep.
// -----------------------------------------------------------------------------
module tb_mode_start_ctrl;

   localparam int N     = 2;
   localparam int DB    = 4;
   localparam int ERRC  = 32;
   localparam int BEEPC = 64;

   logic         clk;
   logic         rst;
   logic [N-1:0] mode_sw_i;
   logic         start_i;
   logic         buzzer_mode_i;
   logic [N-1:0] done_i;
   logic [N-1:0] mode_start_o;
   logic [N-1:0] mode_led_o;
   logic         led_idle_o;
   logic         busy_o;
   logic [0:0]   active_mode_o;
   logic         done_o;
   logic         err_o;
   logic         buzzer_o;

   mode_start_ctrl #(
      .N_MODES         (N),
      .DEBOUNCE_CYCLES (DB),
      .ERR_CYCLES      (ERRC),
      .BEEP_CYCLES     (BEEPC)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .mode_sw_i     (mode_sw_i),
      .start_i       (start_i),
      .buzzer_mode_i (buzzer_mode_i),
      .done_i        (done_i),
      .mode_start_o  (mode_start_o),
      .mode_led_o    (mode_led_o),
      .led_idle_o    (led_idle_o),
      .busy_o        (busy_o),
      .active_mode_o (active_mode_o),
      .done_o        (done_o),
      .err_o         (err_o),
      .buzzer_o      (buzzer_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int start_pulses = 0;
   int done_pulses  = 0;

   // Count every cycle in which a start pulse or done pulse is present
   always @(posedge clk) begin
      if (mode_start_o != 2'b00) start_pulses++;
      if (done_o) done_pulses++;
   end

   // Packed output word: {mode_start, mode_led, idle, busy, active, done, err, buzzer}
   localparam logic [9:0] RST_OUT  = 10'b00_00_1_0_0_0_0_0;
   localparam logic [9:0] IDLE_A1  = 10'b00_00_1_0_1_0_0_0;
   localparam logic [9:0] IDLE_A0  = 10'b00_00_1_0_0_0_0_0;

   function automatic logic [9:0] outs();
      return {mode_start_o, mode_led_o, led_idle_o, busy_o, active_mode_o,
              done_o, err_o, buzzer_o};
   endfunction

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [1:0] sw;
      logic       st;
      logic [1:0] dn;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #500000;
      $display("FAIL global_timeout actual=timeout expected=finish");
      $fatal(1, "timeout");
   end

   initial begin
      int sp0;
      int dp0;
      int n;
      int hi;

      // Vector table: inputs before edge k, expected outputs after edge k.
      // Start seen at edge 0, pulse at edge 0+2+DB+1 = 7.
      for (int k = 0; k < 7; k++) begin
         vecs[k] = '{sw: 2'b10, st: 1'b1, dn: 2'b00, exp: IDLE_A0};
      end
      vecs[7]  = '{sw: 2'b10, st: 1'b1, dn: 2'b00, exp: 10'b10_10_0_1_1_0_0_0};
      vecs[8]  = '{sw: 2'b10, st: 1'b1, dn: 2'b00, exp: 10'b00_10_0_1_1_0_0_0};
      vecs[9]  = '{sw: 2'b10, st: 1'b1, dn: 2'b01, exp: 10'b00_10_0_1_1_0_0_0};
      vecs[10] = '{sw: 2'b10, st: 1'b1, dn: 2'b10, exp: 10'b00_00_0_0_1_1_0_0};
      vecs[11] = '{sw: 2'b10, st: 1'b1, dn: 2'b00, exp: IDLE_A1};
      vecs[12] = '{sw: 2'b10, st: 1'b1, dn: 2'b00, exp: IDLE_A1};

      // ---- Reset with inputs active ----
      rst = 1'b1;
      mode_sw_i = 2'b01;
      start_i = 1'b1;
      buzzer_mode_i = 1'b0;
      done_i = 2'b00;
      step(10);
      check("reset_outputs", 32'(outs()), 32'(RST_OUT));
      check("reset_no_start", start_pulses, 0);
      start_i = 1'b0;
      step(2);
      rst = 1'b0;
      step(10);
      check("post_reset_idle", 32'(outs()), 32'(IDLE_A0));

      // ---- Table: normal start of mode 1 and completion ----
      for (int k = 0; k < 13; k++) begin
         mode_sw_i = vecs[k].sw;
         start_i   = vecs[k].st;
         done_i    = vecs[k].dn;
         step();
         check($sformatf("vec%0d", k), 32'(outs()), 32'(vecs[k].exp));
      end
      check("table_one_start", start_pulses, 1);
      check("table_one_done", done_pulses, 1);
      start_i = 1'b0;
      done_i = 2'b00;
      step(12);

      // ---- Bounce: 3 high, 2 low, 3 high ----
      sp0 = start_pulses;
      start_i = 1'b1; step(3);
      start_i = 1'b0; step(2);
      start_i = 1'b1; step(3);
      start_i = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step();
         check($sformatf("bounce_idle%0d", k), 32'(outs()), 32'(IDLE_A1));
      end
      check("bounce_no_start", start_pulses, sp0);

      // ---- Illegal selections: 2'b11 then 2'b00 ----
      for (int t = 0; t < 2; t++) begin
         sp0 = start_pulses;
         mode_sw_i = (t == 0) ? 2'b11 : 2'b00;
         step(3);
         start_i = 1'b1;
         n = 0;
         while (!err_o && n < 30) begin
            step();
            n++;
         end
         check($sformatf("err%0d_rise", t), 32'(err_o), 32'd1);
         check($sformatf("err%0d_pattern", t),
               32'({mode_led_o, led_idle_o, busy_o}), 32'(4'b11_0_0));
         hi = 0;
         while (err_o && hi < 100) begin
            // release, then re-press so a start event lands inside ERR
            if (hi == 2)  start_i = 1'b0;
            if (hi == 10) start_i = 1'b1;
            if (hi == 20) start_i = 1'b0;
            step();
            hi++;
         end
         check($sformatf("err%0d_len", t), hi, ERRC);
         start_i = 1'b0;
         step(10);
         check($sformatf("err%0d_back_idle", t), 32'(outs()), 32'(IDLE_A1));
         check($sformatf("err%0d_no_start", t), start_pulses, sp0);
      end

      // ---- Run interference on mode 0, then reset mid-run ----
      sp0 = start_pulses;
      mode_sw_i = 2'b01;
      step(3);
      start_i = 1'b1;
      n = 0;
      while (mode_start_o == 2'b00 && n < 20) begin
         step();
         n++;
      end
      check("run0_start", 32'(mode_start_o), 32'(2'b01));
      check("run0_active", 32'(active_mode_o), 32'd0);
      step();
      mode_sw_i = 2'b10; step(3);
      mode_sw_i = 2'b11; start_i = 1'b0; step(8);
      start_i = 1'b1; step(10);
      start_i = 1'b0; step(8);
      done_i = 2'b10; step();
      done_i = 2'b00; step();
      check("run0_still_busy", 32'(outs()), 32'(10'b00_01_0_1_0_0_0_0));
      check("run0_one_start", start_pulses, sp0 + 1);
      dp0 = done_pulses;
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset_outputs", 32'(outs()), 32'(RST_OUT));
      done_i = 2'b01;
      step(3);
      done_i = 2'b00;
      rst = 1'b0;
      step(5);
      check("after_reset_idle", 32'(outs()), 32'(IDLE_A0));
      check("reset_no_done", done_pulses, dp0);

      // ---- Completion beep ----
      buzzer_mode_i = 1'b1;
      mode_sw_i = 2'b01;
      step(3);
      start_i = 1'b1;
      n = 0;
      while (mode_start_o == 2'b00 && n < 20) begin
         step();
         n++;
      end
      check("beep_run_start", 32'(mode_start_o), 32'(2'b01));
      start_i = 1'b0;
      step(3);
      done_i = 2'b01;
      step();
      done_i = 2'b00;
      check("beep_done_pulse", 32'(done_o), 32'd1);
      check("beep_not_yet", 32'(buzzer_o), 32'd0);
`ifdef DONE_BEEP_EN
      step();
      hi = 0;
      while (buzzer_o && hi < 200) begin
         step();
         hi++;
      end
      check("beep_len", hi, BEEPC);
`else
      hi = 0;
      repeat (80) begin
         step();
         if (buzzer_o) hi++;
      end
      check("beep_absent", hi, 0);
`endif
      buzzer_mode_i = 1'b0;
      step(2);
      check("final_idle", 32'(outs()), 32'(IDLE_A0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
